// File: rtl/gpu_pkg.sv
// gpu_pkg: shared definitions for the GPUREAD path.
//   - GP1(10h) "get GPU info" index constants
//   - rd_state_t: VRAM-to-CPU transfer state encoding
//   - transfer word-count limits and the count-load helper
package gpu_pkg;

  // GP1(10h) info indices that produce a new latch value
  localparam logic [3:0] INFO_TEXWIN = 4'd2;
  localparam logic [3:0] INFO_DRAWTL = 4'd3;
  localparam logic [3:0] INFO_DRAWBR = 4'd4;
  localparam logic [3:0] INFO_OFFSET = 4'd5;
  localparam logic [3:0] INFO_TYPE   = 4'd7;
  localparam logic [3:0] INFO_ZERO   = 4'd8;

  // A full-VRAM transfer is 1024x512 halfwords = 262144 words, which needs
  // 19 bits of count (one more than the 18 bits that a 0 encoding fits).
  localparam int unsigned XFER_MAX_WORDS = 262144;
  localparam int          XFER_CNT_W     = 19;

  typedef enum logic [1:0] {
    IDLE = 2'd0,  // no transfer
    WAIT = 2'd1,  // waiting for the next word from the VRAM engine
    HOLD = 2'd2   // a word sits in GPUREAD until the CPU reads it
  } rd_state_t;

  // A requested word count of 0 stands for the maximum transfer size.
  function automatic logic [XFER_CNT_W-1:0] xfer_load(input logic [XFER_CNT_W-1:0] words);
    return (words == '0) ? XFER_CNT_W'(XFER_MAX_WORDS) : words;
  endfunction

endpackage

// File: rtl/gpu_info_format.sv
// gpu_info_format: combinational formatter for GP1(10h) "get GPU info".
// Ports:
//   i_infoIndex        raw GP1 parameter bits [3:0]
//   i_offsetX/Y        11-bit signed drawing offset
//   i_texWin*          5-bit texture window mask/offset
//   i_drawX0..Y1       10-bit draw area corners
//   o_infoWord         formatted 32-bit word (unused bits zero)
//   o_infoValid        index produces a new GPUREAD value
module gpu_info_format
  import gpu_pkg::*;
#(
  parameter int NEW_GPU  = 0,
  parameter int GPU_TYPE = 2
) (
  input  logic [3:0]  i_infoIndex,
  input  logic [10:0] i_offsetX,
  input  logic [10:0] i_offsetY,
  input  logic [4:0]  i_texWinMaskX,
  input  logic [4:0]  i_texWinMaskY,
  input  logic [4:0]  i_texWinOffX,
  input  logic [4:0]  i_texWinOffY,
  input  logic [9:0]  i_drawX0,
  input  logic [9:0]  i_drawY0,
  input  logic [9:0]  i_drawX1,
  input  logic [9:0]  i_drawY1,
  output logic [31:0] o_infoWord,
  output logic        o_infoValid
);

  logic [3:0] eff_idx;

  // The old GPU decodes only three parameter bits, so 8..15 alias 0..7.
  assign eff_idx = (NEW_GPU != 0) ? i_infoIndex : {1'b0, i_infoIndex[2:0]};

  // Old GPU draw-area Y is 9 bits; bit 9 is simply not reported.
  function automatic logic [31:0] draw_corner(input logic [9:0] x, input logic [9:0] y);
    if (NEW_GPU != 0) begin
      return {12'b0, y, x};
    end
    return {13'b0, y[8:0], x};
  endfunction

  always_comb begin
    o_infoWord  = '0;
    o_infoValid = 1'b0;
    case (eff_idx)
      INFO_TEXWIN: begin
        o_infoWord  = {12'b0, i_texWinOffY, i_texWinOffX, i_texWinMaskY, i_texWinMaskX};
        o_infoValid = 1'b1;
      end
      INFO_DRAWTL: begin
        o_infoWord  = draw_corner(i_drawX0, i_drawY0);
        o_infoValid = 1'b1;
      end
      INFO_DRAWBR: begin
        o_infoWord  = draw_corner(i_drawX1, i_drawY1);
        o_infoValid = 1'b1;
      end
      INFO_OFFSET: begin
        o_infoWord  = {10'b0, i_offsetY, i_offsetX};
        o_infoValid = 1'b1;
      end
      INFO_TYPE: begin
        o_infoWord  = 32'(GPU_TYPE);
        o_infoValid = 1'b1;
      end
      INFO_ZERO: begin
        o_infoWord  = '0;
        o_infoValid = 1'b1;
      end
      default: begin
        o_infoWord  = '0;
        o_infoValid = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/gpu_read_responder.sv
// gpu_read_responder: owns the GPUREAD latch.
//   - GP1(10h) info requests load a formatted draw-state word (1-cycle latency)
//   - C0h VRAM-to-CPU transfers stream words from the VRAM engine to the CPU,
//     one word held in GPUREAD at a time
// Ports:
//   i_clk, i_nrst        clock, asynchronous active-low reset
//   i_infoReq/Index      GP1(10h) request pulse and parameter
//   i_offset*, i_texWin*, i_draw*   GP0 draw-state register values
//   i_xferStart/Words    C0h start pulse and word count (0 = 262144)
//   i_xferAbort          GP1(00h/01h) transfer reset pulse
//   i_vramWord/Valid, o_vramReady   VRAM engine handshake
//   i_cpuRead            CPU read strobe of GPUREAD
//   o_gpuRead            GPUREAD latch
//   o_readReady          GPUSTAT bit 27 (word waiting for the CPU)
//   o_xferBusy           transfer in progress
module gpu_read_responder
  import gpu_pkg::*;
#(
  parameter int NEW_GPU  = 0,
  parameter int GPU_TYPE = 2
) (
  input  logic        i_clk,
  input  logic        i_nrst,
  input  logic        i_infoReq,
  input  logic [3:0]  i_infoIndex,
  input  logic [10:0] i_offsetX,
  input  logic [10:0] i_offsetY,
  input  logic [4:0]  i_texWinMaskX,
  input  logic [4:0]  i_texWinMaskY,
  input  logic [4:0]  i_texWinOffX,
  input  logic [4:0]  i_texWinOffY,
  input  logic [9:0]  i_drawX0,
  input  logic [9:0]  i_drawY0,
  input  logic [9:0]  i_drawX1,
  input  logic [9:0]  i_drawY1,
  input  logic        i_xferStart,
  input  logic [18:0] i_xferWords,
  input  logic        i_xferAbort,
  input  logic [31:0] i_vramWord,
  input  logic        i_vramValid,
  output logic        o_vramReady,
  input  logic        i_cpuRead,
  output logic [31:0] o_gpuRead,
  output logic        o_readReady,
  output logic        o_xferBusy
);

  rd_state_t             state_q, state_d;
  logic [XFER_CNT_W-1:0] count_q, count_d;
  logic [31:0]           latch_q, latch_d;

  logic [31:0] info_word;
  logic        info_valid;
  logic        info_hit;
  logic        vram_accept;
  logic        word_consumed;

  gpu_info_format #(
    .NEW_GPU  (NEW_GPU),
    .GPU_TYPE (GPU_TYPE)
  ) u_info_format (
    .i_infoIndex   (i_infoIndex),
    .i_offsetX     (i_offsetX),
    .i_offsetY     (i_offsetY),
    .i_texWinMaskX (i_texWinMaskX),
    .i_texWinMaskY (i_texWinMaskY),
    .i_texWinOffX  (i_texWinOffX),
    .i_texWinOffY  (i_texWinOffY),
    .i_drawX0      (i_drawX0),
    .i_drawY0      (i_drawY0),
    .i_drawX1      (i_drawX1),
    .i_drawY1      (i_drawY1),
    .o_infoWord    (info_word),
    .o_infoValid   (info_valid)
  );

  // Only indices that actually rewrite the latch count as an info hit;
  // the others leave GPUREAD (and thus any held VRAM word) untouched.
  assign info_hit      = i_infoReq & info_valid;
  assign vram_accept   = (state_q == WAIT) & i_vramValid;
  // An info word overwriting a held VRAM word destroys it, so it retires
  // that word exactly like a CPU read; both together still retire one.
  assign word_consumed = (state_q == HOLD) & (i_cpuRead | info_hit);

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    latch_d = latch_q;

    if (i_xferAbort) begin
      // Abort wins over everything, including a same-cycle info request.
      state_d = IDLE;
      count_d = '0;
    end else begin
      if (i_xferStart) begin
        state_d = WAIT;
        count_d = xfer_load(i_xferWords);
      end else begin
        case (state_q)
          WAIT: begin
            if (vram_accept) begin
              state_d = HOLD;
              latch_d = i_vramWord;
            end
          end
          HOLD: begin
            if (word_consumed) begin
              // count is never 0 in HOLD; the guard keeps it from wrapping
              if (count_q != '0) begin
                count_d = count_q - 1'b1;
              end
              state_d = (count_q <= 19'd1) ? IDLE : WAIT;
            end
          end
          default: begin
            state_d = state_q;
          end
        endcase
      end

      // Info word has last say on the latch, even over an accepted VRAM word.
      if (info_hit) begin
        latch_d = info_word;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      state_q <= IDLE;
      count_q <= '0;
      latch_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      latch_q <= latch_d;
    end
  end

  assign o_vramReady = (state_q == WAIT);
  assign o_readReady = (state_q == HOLD);
  assign o_xferBusy  = (state_q != IDLE);
  assign o_gpuRead   = latch_q;

endmodule

// File: tb/tb_gpu_read_responder.sv
module tb_gpu_read_responder;

  logic        clk = 1'b0;
  logic        nrst;
  logic        infoReq;
  logic [3:0]  infoIndex;
  logic [10:0] offsetX, offsetY;
  logic [4:0]  twMaskX, twMaskY, twOffX, twOffY;
  logic [9:0]  drawX0, drawY0, drawX1, drawY1;
  logic        xferStart;
  logic [18:0] xferWords;
  logic        xferAbort;
  logic [31:0] vramWord;
  logic        vramValid;
  logic        cpuRead;

  logic        vramReady, readReady, xferBusy;
  logic [31:0] gpuRead;
  logic        n_vramReady, n_readReady, n_xferBusy;
  logic [31:0] n_gpuRead;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  gpu_read_responder #(.NEW_GPU(0), .GPU_TYPE(2)) dut (
    .i_clk(clk), .i_nrst(nrst),
    .i_infoReq(infoReq), .i_infoIndex(infoIndex),
    .i_offsetX(offsetX), .i_offsetY(offsetY),
    .i_texWinMaskX(twMaskX), .i_texWinMaskY(twMaskY),
    .i_texWinOffX(twOffX), .i_texWinOffY(twOffY),
    .i_drawX0(drawX0), .i_drawY0(drawY0), .i_drawX1(drawX1), .i_drawY1(drawY1),
    .i_xferStart(xferStart), .i_xferWords(xferWords), .i_xferAbort(xferAbort),
    .i_vramWord(vramWord), .i_vramValid(vramValid), .o_vramReady(vramReady),
    .i_cpuRead(cpuRead), .o_gpuRead(gpuRead),
    .o_readReady(readReady), .o_xferBusy(xferBusy)
  );

  // Second instance with the 208-pin layout, fed the same stimulus.
  gpu_read_responder #(.NEW_GPU(1), .GPU_TYPE(2)) dut_new (
    .i_clk(clk), .i_nrst(nrst),
    .i_infoReq(infoReq), .i_infoIndex(infoIndex),
    .i_offsetX(offsetX), .i_offsetY(offsetY),
    .i_texWinMaskX(twMaskX), .i_texWinMaskY(twMaskY),
    .i_texWinOffX(twOffX), .i_texWinOffY(twOffY),
    .i_drawX0(drawX0), .i_drawY0(drawY0), .i_drawX1(drawX1), .i_drawY1(drawY1),
    .i_xferStart(xferStart), .i_xferWords(xferWords), .i_xferAbort(xferAbort),
    .i_vramWord(vramWord), .i_vramValid(vramValid), .o_vramReady(n_vramReady),
    .i_cpuRead(cpuRead), .o_gpuRead(n_gpuRead),
    .o_readReady(n_readReady), .o_xferBusy(n_xferBusy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock and drop all single-cycle strobes.
  task automatic tick();
    @(posedge clk);
    #1;
    infoReq   = 1'b0;
    xferStart = 1'b0;
    xferAbort = 1'b0;
    cpuRead   = 1'b0;
    vramValid = 1'b0;
  endtask

  task automatic info(input logic [3:0] idx);
    infoReq   = 1'b1;
    infoIndex = idx;
    tick();
  endtask

  initial begin
    nrst = 1'b0;
    infoReq = 1'b0; infoIndex = '0;
    offsetX = '0; offsetY = '0;
    twMaskX = '0; twMaskY = '0; twOffX = '0; twOffY = '0;
    drawX0 = '0; drawY0 = '0; drawX1 = '0; drawY1 = '0;
    xferStart = 1'b0; xferWords = '0; xferAbort = 1'b0;
    vramWord = '0; vramValid = 1'b0; cpuRead = 1'b0;

    #12;
    chk("rst_gpuread", gpuRead, 32'h0);
    chk("rst_readready", {31'b0, readReady}, 32'h0);
    chk("rst_vramready", {31'b0, vramReady}, 32'h0);
    chk("rst_busy", {31'b0, xferBusy}, 32'h0);
    nrst = 1'b1;
    tick();
    cpuRead = 1'b1;
    tick();
    chk("idle_read_noeffect", gpuRead, 32'h0);

    // ---- info formats ----
    offsetX = 11'h7FB;  // -5
    offsetY = 11'd3;
    info(4'd5);
    chk("info_offset", gpuRead, 32'h00001FFB);
    chk("info_offset_new", n_gpuRead, 32'h00001FFB);

    drawY0 = 10'h3FF;
    drawX0 = 10'h155;
    info(4'd3);
    chk("info_drawtl_old", gpuRead, 32'h0007FD55);
    chk("info_drawtl_new", n_gpuRead, 32'h000FFD55);

    drawX1 = 10'h2AA;
    drawY1 = 10'h123;
    info(4'd4);
    chk("info_drawbr_old", gpuRead, 32'h00048EAA);
    chk("info_drawbr_new", n_gpuRead, 32'h00048EAA);

    info(4'd0);
    chk("info_idx0_keep", gpuRead, 32'h00048EAA);
    info(4'd6);
    chk("info_idx6_keep", gpuRead, 32'h00048EAA);
    info(4'd9);
    chk("info_idx9_keep", gpuRead, 32'h00048EAA);
    chk("info_idx9_keep_new", n_gpuRead, 32'h00048EAA);

    info(4'd7);
    chk("info_type", gpuRead, 32'h2);
    info(4'd8);
    chk("info_idx8_old_alias0", gpuRead, 32'h2);
    chk("info_zero_new", n_gpuRead, 32'h0);
    info(4'd13);
    chk("info_idx13_old_alias5", gpuRead, 32'h00001FFB);
    chk("info_idx13_new_keep", n_gpuRead, 32'h0);

    // ---- 3-word transfer with an info request stealing word B ----
    xferStart = 1'b1; xferWords = 19'd3;
    tick();
    chk("x3_wait_ready", {31'b0, vramReady}, 32'h1);
    chk("x3_wait_noheld", {31'b0, readReady}, 32'h0);
    chk("x3_busy", {31'b0, xferBusy}, 32'h1);
    tick();
    chk("x3_gap_still_wait", {31'b0, vramReady}, 32'h1);
    vramValid = 1'b1; vramWord = 32'hAAAA0001;
    tick();
    chk("x3_A_held", {31'b0, readReady}, 32'h1);
    chk("x3_A_noready", {31'b0, vramReady}, 32'h0);
    chk("x3_A_data", gpuRead, 32'hAAAA0001);
    vramValid = 1'b1; vramWord = 32'hDEADBEEF;
    tick();
    chk("x3_hold_rejects", gpuRead, 32'hAAAA0001);
    cpuRead = 1'b1;
    tick();
    chk("x3_A_read_wait", {31'b0, vramReady}, 32'h1);
    chk("x3_A_read_noheld", {31'b0, readReady}, 32'h0);
    cpuRead = 1'b1;
    tick();
    chk("x3_wait_read_noeffect", {31'b0, vramReady}, 32'h1);
    vramValid = 1'b1; vramWord = 32'hBBBB0002;
    tick();
    chk("x3_B_data", gpuRead, 32'hBBBB0002);
    twMaskX = 5'd1; twMaskY = 5'd2; twOffX = 5'd3; twOffY = 5'd4;
    info(4'd2);
    chk("x3_texwin_over_B", gpuRead, 32'h00020C41);
    chk("x3_B_lost_wait", {31'b0, vramReady}, 32'h1);
    vramValid = 1'b1; vramWord = 32'hCCCC0003;
    tick();
    chk("x3_C_data", gpuRead, 32'hCCCC0003);
    cpuRead = 1'b1;
    tick();
    chk("x3_done_idle", {31'b0, xferBusy}, 32'h0);
    chk("x3_done_noready", {31'b0, vramReady}, 32'h0);
    chk("x3_done_keep", gpuRead, 32'hCCCC0003);

    // ---- info + accept, then info + read (single decrement) ----
    xferStart = 1'b1; xferWords = 19'd2;
    tick();
    vramValid = 1'b1; vramWord = 32'hD0D0D0D0;
    infoReq = 1'b1; infoIndex = 4'd7;
    tick();
    chk("sim_info_wins", gpuRead, 32'h2);
    chk("sim_accept_hold", {31'b0, readReady}, 32'h1);
    infoReq = 1'b1; infoIndex = 4'd7; cpuRead = 1'b1;
    tick();
    chk("sim_single_dec", {31'b0, vramReady}, 32'h1);
    vramValid = 1'b1; vramWord = 32'hE0E0E0E0;
    tick();
    cpuRead = 1'b1;
    tick();
    chk("sim_end_idle", {31'b0, xferBusy}, 32'h0);

    // ---- abort in WAIT ----
    xferStart = 1'b1; xferWords = 19'd100;
    tick();
    xferAbort = 1'b1;
    vramValid = 1'b1; vramWord = 32'h12345678;
    tick();
    chk("abort_idle", {31'b0, xferBusy}, 32'h0);
    chk("abort_noready", {31'b0, vramReady}, 32'h0);
    chk("abort_keep", gpuRead, 32'hE0E0E0E0);

    // ---- restart from HOLD ----
    xferStart = 1'b1; xferWords = 19'd5;
    tick();
    vramValid = 1'b1; vramWord = 32'h0F0F0F0F;
    tick();
    xferStart = 1'b1; xferWords = 19'd1;
    tick();
    chk("restart_wait", {31'b0, vramReady}, 32'h1);
    vramValid = 1'b1; vramWord = 32'h5A5A5A5A;
    tick();
    cpuRead = 1'b1;
    tick();
    chk("restart_count1_idle", {31'b0, xferBusy}, 32'h0);

    // ---- async reset mid-HOLD ----
    xferStart = 1'b1; xferWords = 19'd2;
    tick();
    vramValid = 1'b1; vramWord = 32'h77777777;
    tick();
    chk("prerst_hold", {31'b0, readReady}, 32'h1);
    nrst = 1'b0;
    #1;
    chk("midrst_gpuread", gpuRead, 32'h0);
    chk("midrst_readready", {31'b0, readReady}, 32'h0);
    chk("midrst_busy", {31'b0, xferBusy}, 32'h0);
    #2;
    nrst = 1'b1;
    tick();

    // ---- word count 0 means maximum: runs well past any small count ----
    xferStart = 1'b1; xferWords = 19'd0;
    tick();
    for (int i = 0; i < 40; i++) begin
      vramValid = 1'b1; vramWord = 32'h1000 + i;
      tick();
      chk("max_held", gpuRead, 32'h1000 + i);
      cpuRead = 1'b1;
      tick();
      chk("max_still_busy", {31'b0, vramReady}, 32'h1);
    end
    xferAbort = 1'b1;
    tick();
    chk("max_abort_idle", {31'b0, xferBusy}, 32'h0);

    // ---- count reaching 0 stays in IDLE ----
    xferStart = 1'b1; xferWords = 19'd1;
    tick();
    vramValid = 1'b1; vramWord = 32'h00000011;
    tick();
    cpuRead = 1'b1;
    tick();
    chk("nowrap_idle", {31'b0, xferBusy}, 32'h0);
    cpuRead = 1'b1;
    vramValid = 1'b1; vramWord = 32'h99999999;
    tick();
    chk("nowrap_stay_idle", {31'b0, xferBusy}, 32'h0);
    chk("nowrap_keep", gpuRead, 32'h00000011);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
